// File: rtl/irq_dispatch_arbiter.sv
// Interrupt dispatch core: latches edge/level sources, picks one eligible source
// round-robin, runs the ack/end-of-interrupt handshake and a post-EOI hold-off.
module irq_dispatch_arbiter #(
  parameter int NUM_SRC   = 8,
  parameter int ID_W      = $clog2(NUM_SRC),
  parameter int HOLDOFF_W = 8
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic [NUM_SRC-1:0]   src_irq,
  input  logic [NUM_SRC-1:0]   cfg_enable,
  input  logic [NUM_SRC-1:0]   cfg_edge,
  input  logic [NUM_SRC-1:0]   cfg_clear,
  input  logic [HOLDOFF_W-1:0] cfg_holdoff,
  output logic [NUM_SRC-1:0]   pending,
  output logic                 irq_req,
  output logic [ID_W-1:0]      irq_id,
  input  logic                 irq_ack,
  input  logic                 irq_eoi,
  output logic                 busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ASSERT,
    ST_SERVICE,
    ST_HOLDOFF
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_SRC-1:0]    pend_q, pend_d;
  logic [NUM_SRC-1:0]    src_dly_q;
  logic                  irq_req_q, irq_req_d;
  logic [ID_W-1:0]       irq_id_q, irq_id_d;
  logic                  busy_q, busy_d;
  logic [ID_W-1:0]       rr_last_q, rr_last_d;
  logic [HOLDOFF_W-1:0]  cnt_q, cnt_d;

  logic [NUM_SRC-1:0]    eligible;
  logic                  ack_take;
  logic [NUM_SRC-1:0]    grant_clr;
  logic                  hi_found;
  logic [ID_W-1:0]       sel_hi, sel_any, sel;

  assign eligible = pend_q & cfg_enable;
  assign ack_take = (state_q == ST_ASSERT) && irq_ack;

  // Pending latch: edge sources set on a rising edge and clear on W1C or ack
  // (set has priority); level sources simply follow the line.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_clr = '0;
    pend_d    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      grant_clr[i] = ack_take && (irq_id_q == ID_W'(i));
      if (cfg_edge[i]) begin
        pend_d[i] = (src_irq[i] & ~src_dly_q[i]) |
                    (pend_q[i] & ~(cfg_clear[i] | grant_clr[i]));
      end else begin
        pend_d[i] = src_irq[i];
      end
    end
  end

  // Round-robin pick: lowest eligible index above rr_last, else lowest overall.
  always_comb begin
    hi_found = 1'b0;
    sel_hi   = '0;
    sel_any  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_any = ID_W'(i);
        if (ID_W'(i) > rr_last_q) begin
          sel_hi   = ID_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    sel = hi_found ? sel_hi : sel_any;
  end

  always_comb begin
    state_d   = state_q;
    irq_id_d  = irq_id_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|eligible) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (|eligible) begin
          irq_id_d  = sel;
          rr_last_d = sel;
          state_d   = ST_ASSERT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        // An ack in the same cycle as withdrawal still completes the handshake.
        if (irq_ack)                    state_d = ST_SERVICE;
        else if (!eligible[irq_id_q])   state_d = ST_IDLE;
      end
      ST_SERVICE: begin
        if (irq_eoi) begin
          if (cfg_holdoff == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cfg_holdoff;
            state_d = ST_HOLDOFF;
          end
        end
      end
      ST_HOLDOFF: begin
        cnt_d = cnt_q - HOLDOFF_W'(1);
        if (cnt_q <= HOLDOFF_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    irq_req_d = (state_d == ST_ASSERT);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      src_dly_q <= '0;
      irq_req_q <= 1'b0;
      irq_id_q  <= '0;
      busy_q    <= 1'b0;
      rr_last_q <= ID_W'(NUM_SRC - 1);
      cnt_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q   <= state_d;
      pend_q    <= pend_d;
      src_dly_q <= src_irq;
      irq_req_q <= irq_req_d;
      irq_id_q  <= irq_id_d;
      busy_q    <= busy_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending = pend_q;
  assign irq_req = irq_req_q;
  assign irq_id  = irq_id_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_irq_dispatch_arbiter.sv
// Self-checking bench for irq_dispatch_arbiter: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_irq_dispatch_arbiter;

  localparam int N = 8;
  localparam int P_IDLE    = 0;
  localparam int P_ARB     = 1;
  localparam int P_ASSERT  = 2;
  localparam int P_SERVICE = 3;
  localparam int P_HOLD    = 4;

  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b1;
  logic [7:0] src_irq = '0;
  logic [7:0] cfg_enable = '0;
  logic [7:0] cfg_edge = '0;
  logic [7:0] cfg_clear = '0;
  logic [7:0] cfg_holdoff = '0;
  logic [7:0] pending;
  logic       irq_req;
  logic [2:0] irq_id;
  logic       irq_ack = 1'b0;
  logic       irq_eoi = 1'b0;
  logic       busy;

  int tests = 0;
  int fails = 0;

  irq_dispatch_arbiter #(.NUM_SRC(8), .ID_W(3), .HOLDOFF_W(8)) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .src_irq     (src_irq),
    .cfg_enable  (cfg_enable),
    .cfg_edge    (cfg_edge),
    .cfg_clear   (cfg_clear),
    .cfg_holdoff (cfg_holdoff),
    .pending     (pending),
    .irq_req     (irq_req),
    .irq_id      (irq_id),
    .irq_ack     (irq_ack),
    .irq_eoi     (irq_eoi),
    .busy        (busy)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase, pending set and round-robin pointer per the rules.
  int         m_phase = P_IDLE;
  logic [7:0] m_pend = '0;
  logic [7:0] m_srcd = '0;
  int         m_id = 0;
  int         m_rr = N - 1;
  int         m_cnt = 0;
  logic [7:0] m_elig;
  logic [7:0] m_next;
  logic [2:0] m_idx;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      m_phase = P_IDLE;
      m_pend  = '0;
      m_srcd  = '0;
      m_id    = 0;
      m_rr    = N - 1;
      m_cnt   = 0;
    end else begin
      m_elig = m_pend & cfg_enable;
      for (int i = 0; i < N; i++) begin
        if (cfg_edge[i])
          m_next[i] = (src_irq[i] && !m_srcd[i]) ||
                      (m_pend[i] && !cfg_clear[i] &&
                       !(m_phase == P_ASSERT && irq_ack && m_id == i));
        else
          m_next[i] = src_irq[i];
      end
      case (m_phase)
        P_IDLE: if (m_elig != 0) m_phase = P_ARB;
        P_ARB: begin
          m_phase = P_IDLE;
          for (int k = 1; k <= N; k++) begin
            m_idx = 3'((m_rr + k) % N);
            if (m_phase == P_IDLE && m_elig[m_idx]) begin
              m_id    = int'(m_idx);
              m_rr    = m_id;
              m_phase = P_ASSERT;
            end
          end
        end
        P_ASSERT: begin
          if (irq_ack) m_phase = P_SERVICE;
          else if (!m_elig[m_id]) m_phase = P_IDLE;
        end
        P_SERVICE: begin
          if (irq_eoi) begin
            m_cnt   = int'(cfg_holdoff);
            m_phase = (m_cnt == 0) ? P_IDLE : P_HOLD;
          end
        end
        default: begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) m_phase = P_IDLE;
        end
      endcase
      m_pend = m_next;
      m_srcd = src_irq;
    end
  end

  always @(posedge ACLK) begin
    #1;
    if (ARESETN) begin
      check("cyc_pending", 32'(pending), 32'(m_pend));
      check("cyc_irq_req", 32'(irq_req), 32'(m_phase == P_ASSERT));
      check("cyc_busy",    32'(busy),    32'(m_phase != P_IDLE));
      if (m_phase != P_IDLE) check("cyc_irq_id", 32'(irq_id), m_id);
    end
  end

  task automatic do_reset(input int cycles);
    @(negedge ACLK);
    ARESETN = 1'b0;
    src_irq = '0; cfg_clear = '0; irq_ack = 1'b0; irq_eoi = 1'b0;
    repeat (cycles) @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  task automatic pulse_src(input logic [7:0] mask);
    src_irq = mask;
    @(negedge ACLK);
    src_irq = '0;
  endtask

  // Wait (bounded) for irq_req, then check the granted id.
  task automatic wait_grant(input string name, input int exp_id);
    int n;
    n = 0;
    while (irq_req !== 1'b1 && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check({name, "_req"}, 32'(irq_req), 1);
    check({name, "_id"}, 32'(irq_id), exp_id);
  endtask

  task automatic serve(input string name, input int exp_id);
    wait_grant(name, exp_id);
    irq_ack = 1'b1;
    @(negedge ACLK);
    irq_ack = 1'b0;
    check({name, "_req_drop"}, 32'(irq_req), 0);
    irq_eoi = 1'b1;
    @(negedge ACLK);
    irq_eoi = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_req;

    // Reset / idle
    #2 ARESETN = 1'b0;
    repeat (10) @(negedge ACLK);
    check("rst_pending", 32'(pending), 0);
    check("rst_irq_req", 32'(irq_req), 0);
    check("rst_busy",    32'(busy),    0);
    check("rst_irq_id",  32'(irq_id),  0);
    ARESETN = 1'b1;

    // Single edge source 5 with hold-off 4
    cfg_enable = 8'hFF; cfg_edge = 8'hFF; cfg_holdoff = 8'd4;
    @(negedge ACLK);
    pulse_src(8'h20);
    check("single_pending", 32'(pending), 32'h20);
    check("single_noreq0",  32'(irq_req), 0);
    @(negedge ACLK);
    check("single_arb_busy", 32'(busy),    1);
    check("single_noreq1",   32'(irq_req), 0);
    @(negedge ACLK);
    check("single_req", 32'(irq_req), 1);
    check("single_id",  32'(irq_id),  5);
    irq_ack = 1'b1;
    @(negedge ACLK);
    irq_ack = 1'b0;
    check("single_ack_req",  32'(irq_req), 0);
    check("single_ack_pend", 32'(pending), 0);
    check("single_svc_busy", 32'(busy),    1);
    irq_eoi = 1'b1;
    @(negedge ACLK);
    irq_eoi = 1'b0;
    repeat (3) @(negedge ACLK);
    check("single_hold_busy", 32'(busy), 1);
    @(negedge ACLK);
    check("single_idle_busy", 32'(busy), 0);

    // Round-robin 1,3,6 twice (wraps past 7)
    do_reset(3);
    cfg_holdoff = 8'd0;
    @(negedge ACLK);
    pulse_src(8'h4A);
    serve("rr_a1", 1);
    serve("rr_a3", 3);
    serve("rr_a6", 6);
    pulse_src(8'h4A);
    serve("rr_b1", 1);
    serve("rr_b3", 3);
    serve("rr_b6", 6);

    // Mask then withdraw by W1C clear during ASSERT
    do_reset(3);
    cfg_enable = 8'hFB;
    @(negedge ACLK);
    pulse_src(8'h04);
    irq_ack = 1'b1;
    @(negedge ACLK);
    irq_ack = 1'b0;
    repeat (2) @(negedge ACLK);
    check("mask_pending", 32'(pending), 32'h04);
    check("mask_noreq",   32'(irq_req), 0);
    check("mask_idle",    32'(busy),    0);
    cfg_enable = 8'hFF;
    wait_grant("mask_grant", 2);
    cfg_clear = 8'h04;
    @(negedge ACLK);
    cfg_clear = 8'h00;
    check("withdraw_req_hold", 32'(irq_req), 1);
    @(negedge ACLK);
    check("withdraw_req", 32'(irq_req), 0);
    check("withdraw_busy", 32'(busy),   0);
    check("withdraw_pend", 32'(pending), 0);

    // Level source 4 with hold-off 2
    do_reset(3);
    cfg_edge = 8'hEF; cfg_holdoff = 8'd2;
    src_irq = 8'h10;
    wait_grant("level_first", 4);
    irq_ack = 1'b1;
    @(negedge ACLK);
    irq_ack = 1'b0;
    check("level_ack_pend", 32'(pending), 32'h10);
    irq_eoi = 1'b1;
    @(negedge ACLK);
    irq_eoi = 1'b0;
    repeat (3) @(negedge ACLK);
    check("level_gap_noreq", 32'(irq_req), 0);
    @(negedge ACLK);
    check("level_second_req", 32'(irq_req), 1);
    check("level_second_id",  32'(irq_id),  4);
    src_irq = 8'h00;
    @(negedge ACLK);
    check("level_drop_pend", 32'(pending), 0);
    repeat (3) @(negedge ACLK);

    // Asynchronous reset while asserting id 3
    do_reset(3);
    cfg_edge = 8'hFF; cfg_holdoff = 8'd0;
    @(negedge ACLK);
    pulse_src(8'h08);
    wait_grant("areset_grant", 3);
    #2 ARESETN = 1'b0;
    #1;
    check("areset_req",  32'(irq_req), 0);
    check("areset_busy", 32'(busy),    0);
    check("areset_pend", 32'(pending), 0);
    check("areset_id",   32'(irq_id),  0);
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    saw_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge ACLK);
      if (irq_req === 1'b1 || busy === 1'b1) saw_req = 1'b1;
    end
    check("areset_no_dispatch", 32'(saw_req), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
